fpadd_sched: RTL and testbench
==============================

# fpadd_sched

Round-robin scheduler that shares one multi-cycle `fpadd` unit among `NREQ` requesters (voice/mixer stages in the DSP path). It accepts one operand pair at a time, pulses the adder's load input and waits for its `done`. It then returns the result to the granted requester. A watchdog aborts an operation that never completes and returns quiet NaN with an error flag.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `MAX_LAT`, 16: watchdog limit in WAIT cycles, 2..255.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `req_valid`, in, NREQ: requester i has an operand pair pending.
- `req_a`, in, 32*NREQ: operand A for requester i, in bits [32i+31:32i], IEEE-754 single.
- `req_b`, in, 32*NREQ: operand B, same packing as `req_a`.
- `req_ready`, out, NREQ: one-hot accept strobe; a transfer happens when `req_valid[i]` and `req_ready[i]` are both high.
- `resp_valid`, out, NREQ: one-hot, one-cycle result strobe.
- `resp_data`, out, 32: result, valid while any `resp_valid` bit is high.
- `resp_err`, out, 1: watchdog timeout flag, qualified by `resp_valid`.
- `busy`, out, 1: high in every state except IDLE.
- `add_load`, out, 1: drives the adder's load/reset input; the adder samples its operands while this is high.
- `add_a`, out, 32: adder operand A, held stable from LOAD until return to IDLE.
- `add_b`, out, 32: adder operand B, held stable the same way.
- `add_done`, in, 1: adder completion level; the adder holds it high until the next load.
- `add_result`, in, 32: adder result, valid while `add_done` is high.

## Operation
- States: IDLE, LOAD, WAIT, RESP. All outputs except `req_ready` are registered.
- **IDLE**
  - The grant is the first requester with `req_valid` high, searching from `last+1` upward and wrapping modulo NREQ.
  - `req_ready[grant]` is high combinationally in this state only.
  - On accept: latch `grant` as `cur`, latch its operands into `add_a`/`add_b`, go to LOAD.
  - No request: stay in IDLE.
- **LOAD**
  - `add_load`=1 for exactly one cycle.
  - Go to WAIT and clear the timer to 0.
- **WAIT**
  - `add_load`=0. The timer increments every cycle and is `clog2(MAX_LAT+1)` bits wide.
  - `add_done` is ignored when the timer is 0, because the adder's stale `done` may still be visible then.
  - If the timer is at least 1 and `add_done`=1: capture `add_result`, set `err`=0, go to RESP.
  - Otherwise, if the timer equals MAX_LAT: set data to 32'h7FC00000, set `err`=1, go to RESP.
  - If `add_done` and the timeout occur in the same cycle, `add_done` wins.
- **RESP**
  - `resp_valid[cur]`=1 for one cycle, with `resp_data` and `resp_err` driven.
  - Set `last`=`cur` and return to IDLE.
- The scheduler does no arithmetic on the operands; they pass through bit-exact.
- A requester must hold `req_valid` and its operands stable until accepted.
- Dropping `req_valid` before accept is legal; that requester simply loses its turn.
- `req_valid` changes after accept have no effect on the operation in flight.

## Timing
- On reset:
  - state is IDLE and `last` is NREQ-1, so requester 0 has first priority;
  - `req_ready`, `resp_valid`, `resp_err`, `busy`, `add_load` and the timer are 0;
  - `resp_data`, `add_a` and `add_b` are 0.
- Reset in any state aborts the operation in flight with no response.
  - `add_load` is forced to 0 in the same clock.
  - Requests accepted earlier must be reissued by the requester.
- Latency, with accept at cycle T:
  - `add_load` is high in T+1.
  - WAIT starts at T+2.
  - If the adder asserts `done` at WAIT timer value k (k≥1), `resp_valid` is high at T+3+k.
  - The earliest next accept is at T+4+k.
- Timeout case: `resp_valid` with `resp_err` is high at T+3+MAX_LAT.
- Fairness: a continuously requesting requester waits at most NREQ-1 operations.

## Test plan
- Single request: requester 2 sends 1.0 (3F800000) + 2.0 (40000000), adder model asserts `done` at k=3 with 40400000 -> `req_ready[2]` at T, `add_load` at T+1 only, `resp_valid[2]` with 40400000 and `resp_err`=0 at T+6.
- All four requesters held valid from reset -> grants in order 0,1,2,3,0; each `resp_valid` bit is one-hot and matches its operand pair.
- Stale done: adder model holds `done`=1 through the LOAD cycle and the first WAIT cycle, then asserts the real `done` at k=2 -> response carries the new result at T+5, not at T+3.
- Watchdog: with MAX_LAT=16 the adder model never asserts `done` -> `resp_data`=7FC00000 and `resp_err`=1 at T+19; the next request is then served normally.
- `done` at the timeout cycle: `done` rises exactly when the timer equals MAX_LAT -> the real result is returned with `resp_err`=0.
- Reset during WAIT -> all outputs return to their reset values the next cycle, no `resp_valid` occurs, and requester 0 wins the next arbitration.

Source files
------------

// File: rtl/fpadd_sched.sv
// fpadd_sched: round-robin scheduler sharing one multi-cycle fpadd unit
// among NREQ requesters. One operand pair is in flight at a time. A
// watchdog returns quiet NaN with resp_err when the adder never finishes.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_a/req_b per-requester operand pairs (32-bit slices)
//   req_ready             one-hot accept strobe (combinational, IDLE only)
//   resp_valid            one-hot one-cycle result strobe
//   resp_data/resp_err    result and timeout flag, qualified by resp_valid
//   busy                  high whenever not IDLE
//   add_load/add_a/add_b  adder load pulse and held operands
//   add_done/add_result   adder completion level and result
//
// state  | meaning
// IDLE   | arbitrate, accept one operand pair
// LOAD   | one-cycle load pulse to the adder
// WAIT   | count cycles until done or watchdog limit
// RESP   | present result to the granted requester
module fpadd_sched #(
   parameter int NREQ    = 4,
   parameter int MAX_LAT = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [32*NREQ-1:0]   req_a,
   input  logic [32*NREQ-1:0]   req_b,
   output logic [NREQ-1:0]      req_ready,
   output logic [NREQ-1:0]      resp_valid,
   output logic [31:0]          resp_data,
   output logic                 resp_err,
   output logic                 busy,
   output logic                 add_load,
   output logic [31:0]          add_a,
   output logic [31:0]          add_b,
   input  logic                 add_done,
   input  logic [31:0]          add_result
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TW = $clog2(MAX_LAT + 1);
   localparam logic [NREQ-1:0] ONE  = {{(NREQ-1){1'b0}}, 1'b1};
   localparam logic [TW-1:0]   TMAX = TW'(MAX_LAT);
   localparam logic [31:0]     QNAN = 32'h7FC0_0000;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_RESP} state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     last_q, last_d;
   logic [IW-1:0]     cur_q, cur_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [NREQ-1:0]   resp_valid_q, resp_valid_d;
   logic [31:0]       resp_data_q, resp_data_d;
   logic              resp_err_q, resp_err_d;
   logic              busy_q, busy_d;
   logic              add_load_q, add_load_d;
   logic [31:0]       add_a_q, add_a_d;
   logic [31:0]       add_b_q, add_b_d;

   logic [31:0]       a_arr [NREQ];
   logic [31:0]       b_arr [NREQ];
   logic [IW-1:0]     grant;
   logic [IW-1:0]     cand;
   logic              grant_vld;
   logic              done_seen;
   logic              timeout;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         a_arr[i] = req_a[32*i +: 32];
         b_arr[i] = req_b[32*i +: 32];
      end
   end

   // Search starts just after the last served requester and wraps.
   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      cand      = '0;
      for (int i = 1; i <= NREQ; i++) begin
         cand = IW'((int'(last_q) + i) % NREQ);
         if (!grant_vld && req_valid[cand]) begin
            grant_vld = 1'b1;
            grant     = cand;
         end
      end
   end

   // A done seen at timer 0 may be left over from the previous operation.
   assign done_seen = (timer_q != '0) && add_done;
   assign timeout   = (timer_q == TMAX);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         last_q       <= IW'(NREQ - 1);
         cur_q        <= '0;
         timer_q      <= '0;
         resp_valid_q <= '0;
         resp_data_q  <= '0;
         resp_err_q   <= 1'b0;
         busy_q       <= 1'b0;
         add_load_q   <= 1'b0;
         add_a_q      <= '0;
         add_b_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         cur_q        <= cur_d;
         timer_q      <= timer_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_err_q   <= resp_err_d;
         busy_q       <= busy_d;
         add_load_q   <= add_load_d;
         add_a_q      <= add_a_d;
         add_b_q      <= add_b_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (grant_vld) state_d = S_LOAD;
         S_LOAD:  state_d = S_WAIT;
         S_WAIT:  if (done_seen || timeout) state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready    = '0;
      last_d       = last_q;
      cur_d        = cur_q;
      timer_d      = timer_q;
      resp_valid_d = '0;
      resp_data_d  = resp_data_q;
      resp_err_d   = resp_err_q;
      add_load_d   = 1'b0;
      add_a_d      = add_a_q;
      add_b_d      = add_b_q;
      case (state_q)
         S_IDLE: begin
            if (grant_vld) begin
               req_ready  = ONE << grant;
               cur_d      = grant;
               add_a_d    = a_arr[grant];
               add_b_d    = b_arr[grant];
               add_load_d = 1'b1;
            end
         end
         S_LOAD: timer_d = '0;
         S_WAIT: begin
            if (done_seen) begin
               resp_data_d  = add_result;
               resp_err_d   = 1'b0;
               resp_valid_d = ONE << cur_q;
            end else if (timeout) begin
               resp_data_d  = QNAN;
               resp_err_d   = 1'b1;
               resp_valid_d = ONE << cur_q;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_RESP: last_d = cur_q;
         default: ;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_err   = resp_err_q;
   assign busy       = busy_q;
   assign add_load   = add_load_q;
   assign add_a      = add_a_q;
   assign add_b      = add_b_q;

endmodule

// File: tb/tb_fpadd_sched.sv
// Directed bench for fpadd_sched: the bench plays the adder by driving
// add_done/add_result on fixed cycles relative to each accept.
module tb_fpadd_sched;
   localparam int NREQ    = 4;
   localparam int MAX_LAT = 16;

   logic                clk = 1'b0;
   logic                reset;
   logic [NREQ-1:0]     req_valid;
   logic [32*NREQ-1:0]  req_a;
   logic [32*NREQ-1:0]  req_b;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ-1:0]     resp_valid;
   logic [31:0]         resp_data;
   logic                resp_err;
   logic                busy;
   logic                add_load;
   logic [31:0]         add_a;
   logic [31:0]         add_b;
   logic                add_done;
   logic [31:0]         add_result;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fpadd_sched #(.NREQ(NREQ), .MAX_LAT(MAX_LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .busy       (busy),
      .add_load   (add_load),
      .add_a      (add_a),
      .add_b      (add_b),
      .add_done   (add_done),
      .add_result (add_result)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_ready"}, 32'(req_ready), 32'h0);
      chk({tag, "_rvalid"}, 32'(resp_valid), 32'h0);
      chk({tag, "_rdata"}, resp_data, 32'h0);
      chk({tag, "_rerr"}, 32'(resp_err), 32'h0);
      chk({tag, "_busy"}, 32'(busy), 32'h0);
      chk({tag, "_load"}, 32'(add_load), 32'h0);
      chk({tag, "_adda"}, add_a, 32'h0);
      chk({tag, "_addb"}, add_b, 32'h0);
   endtask

   initial begin
      int g;
      reset      = 1'b1;
      req_valid  = '0;
      req_a      = '0;
      req_b      = '0;
      add_done   = 1'b0;
      add_result = '0;
      step(3);
      chk_reset("rst");
      reset = 1'b0;
      step(1);

      // Single request from requester 2, adder done at k=3.
      set_req(2, 32'h3F80_0000, 32'h4000_0000);
      req_valid = 4'b0100;
      #1;
      chk("t1_ready", 32'(req_ready), 32'h4);
      step(1);                       // T+1
      req_valid = '0;
      chk("t1_load", 32'(add_load), 32'h1);
      chk("t1_busy", 32'(busy), 32'h1);
      chk("t1_adda", add_a, 32'h3F80_0000);
      chk("t1_addb", add_b, 32'h4000_0000);
      step(1);                       // T+2, timer 0
      chk("t1_load_off", 32'(add_load), 32'h0);
      step(3);                       // T+5, timer 3
      add_done   = 1'b1;
      add_result = 32'h4040_0000;
      chk("t1_early", 32'(resp_valid), 32'h0);
      step(1);                       // T+6
      chk("t1_rvalid", 32'(resp_valid), 32'h4);
      chk("t1_rdata", resp_data, 32'h4040_0000);
      chk("t1_rerr", 32'(resp_err), 32'h0);
      chk("t1_hold_a", add_a, 32'h3F80_0000);
      step(1);                       // back in IDLE
      chk("t1_rvalid_off", 32'(resp_valid), 32'h0);
      chk("t1_idle", 32'(busy), 32'h0);

      // All four requesting from reset: grants 0,1,2,3,0.
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      for (int i = 0; i < NREQ; i++)
         set_req(i, 32'h4100_0000 + 32'(i), 32'h4200_0000 + 32'(i));
      req_valid = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         g = n % NREQ;
         #1;
         chk("t2_ready", 32'(req_ready), 32'h1 << g);
         step(1);                    // LOAD
         add_done = 1'b0;
         chk("t2_adda", add_a, 32'h4100_0000 + 32'(g));
         chk("t2_addb", add_b, 32'h4200_0000 + 32'(g));
         step(2);                    // timer 1
         add_done   = 1'b1;
         add_result = 32'h4300_0000 + 32'(g);
         step(1);                    // RESP
         chk("t2_rvalid", 32'(resp_valid), 32'h1 << g);
         chk("t2_rdata", resp_data, 32'h4300_0000 + 32'(g));
         chk("t2_rerr", 32'(resp_err), 32'h0);
         step(1);
      end
      req_valid = '0;

      // Stale done held through LOAD and timer 0; real done at k=2.
      set_req(1, 32'h3F80_0000, 32'h3F80_0000);
      req_valid = 4'b0010;
      #1;
      chk("t3_ready", 32'(req_ready), 32'h2);
      step(1);                       // T+1, done still high
      req_valid = '0;
      step(1);                       // T+2, timer 0, done still high
      step(1);                       // T+3, timer 1
      add_done = 1'b0;
      chk("t3_no_stale", 32'(resp_valid), 32'h0);
      step(1);                       // T+4, timer 2
      add_done   = 1'b1;
      add_result = 32'h4000_0000;
      chk("t3_early", 32'(resp_valid), 32'h0);
      step(1);                       // T+5
      chk("t3_rvalid", 32'(resp_valid), 32'h2);
      chk("t3_rdata", resp_data, 32'h4000_0000);
      chk("t3_rerr", 32'(resp_err), 32'h0);
      step(1);

      // Watchdog: adder never finishes.
      set_req(3, 32'h4040_0000, 32'h4080_0000);
      req_valid = 4'b1000;
      #1;
      chk("t4_ready", 32'(req_ready), 32'h8);
      step(1);                       // T+1
      req_valid = '0;
      add_done  = 1'b0;
      step(17);                      // T+18
      chk("t4_not_yet", 32'(resp_valid), 32'h0);
      step(1);                       // T+19
      chk("t4_rvalid", 32'(resp_valid), 32'h8);
      chk("t4_rdata", resp_data, 32'h7FC0_0000);
      chk("t4_rerr", 32'(resp_err), 32'h1);
      step(1);
      chk("t4_idle", 32'(busy), 32'h0);
      set_req(0, 32'h4000_0000, 32'h40A0_0000);
      req_valid = 4'b0001;
      #1;
      chk("t4b_ready", 32'(req_ready), 32'h1);
      step(1);
      req_valid = '0;
      step(2);                       // timer 1
      add_done   = 1'b1;
      add_result = 32'h40E0_0000;
      step(1);
      chk("t4b_rvalid", 32'(resp_valid), 32'h1);
      chk("t4b_rdata", resp_data, 32'h40E0_0000);
      chk("t4b_rerr", 32'(resp_err), 32'h0);
      step(1);

      // Done rises exactly when the timer reaches MAX_LAT.
      set_req(0, 32'h4100_0000, 32'h4110_0000);
      req_valid = 4'b0001;
      #1;
      chk("t5_ready", 32'(req_ready), 32'h1);
      step(1);                       // T+1
      req_valid = '0;
      add_done  = 1'b0;
      step(17);                      // T+18, timer == MAX_LAT
      add_done   = 1'b1;
      add_result = 32'h4188_0000;
      chk("t5_not_yet", 32'(resp_valid), 32'h0);
      step(1);                       // T+19
      chk("t5_rvalid", 32'(resp_valid), 32'h1);
      chk("t5_rdata", resp_data, 32'h4188_0000);
      chk("t5_rerr", 32'(resp_err), 32'h0);
      step(1);

      // Reset during WAIT aborts silently and restores priority to 0.
      set_req(2, 32'h4200_0000, 32'h4210_0000);
      req_valid = 4'b0100;
      #1;
      chk("t6_ready", 32'(req_ready), 32'h4);
      step(1);
      req_valid = '0;
      add_done  = 1'b0;
      step(2);                       // WAIT, timer 1
      chk("t6_busy", 32'(busy), 32'h1);
      reset = 1'b1;
      step(1);
      chk_reset("t6_rst");
      reset      = 1'b0;
      add_done   = 1'b1;
      add_result = 32'h4444_4444;
      for (int n = 0; n < 4; n++) begin
         step(1);
         chk("t6_no_resp", 32'(resp_valid), 32'h0);
         chk("t6_no_busy", 32'(busy), 32'h0);
      end
      req_valid = 4'b1111;
      #1;
      chk("t6_prio0", 32'(req_ready), 32'h1);
      req_valid = '0;
      step(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
